// File: rtl/pr_stream_pkg.sv
// ----------------------------------------------------------------------------
// pr_stream_pkg: shared types and constants for the PR bitstream feeder.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pr_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        PR_ST_IDLE         = 3'b000,
        PR_ST_PR_ERROR     = 3'b001,
        PR_ST_CRC_ERROR    = 3'b010,
        PR_ST_INCOMPATIBLE = 3'b011,
        PR_ST_IN_PROGRESS  = 3'b100,
        PR_ST_SUCCESS      = 3'b101
    } pr_status_e;

    localparam logic [2:0] ERR_NONE      = 3'b000;
    localparam logic [2:0] ERR_TIMEOUT   = 3'b110;
    localparam logic [2:0] ERR_PREMATURE = 3'b111;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned PAYLOAD_W = DATA_W + 1;

    // Status codes the IP uses to abort an operation; err_code mirrors them.
    function automatic logic is_ip_fault(input logic [2:0] status);
        return (status == PR_ST_PR_ERROR) || (status == PR_ST_CRC_ERROR) ||
               (status == PR_ST_INCOMPATIBLE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pr_skid_buf.sv
// ----------------------------------------------------------------------------
// pr_skid_buf: 2-entry valid/ready buffer with registered ready and flush.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pr_skid_buf
    import pr_stream_pkg::*;
#(
    parameter int unsigned W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         en_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [W-1:0] mem_q [2];
    logic         rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         push, pop, wr_idx;

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_q];
    assign in_ready_o  = ready_q;

    always_comb begin
        push   = in_valid_i && ready_q;
        pop    = out_valid_o && out_ready_i;
        wr_idx = rd_q ^ cnt_q[0];
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        rd_d   = rd_q ^ pop;
        if (flush_i) begin
            cnt_d = 2'd0;
            rd_d  = 1'b0;
        end
        // Ready is looked up one cycle ahead; the second entry soaks up the
        // word accepted while the registered ready is still catching up.
        ready_d = en_i && !flush_i && (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_idx] <= in_data_i;
            end
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pr_stream_ctrl.sv
// ----------------------------------------------------------------------------
// pr_stream_ctrl: starts a PR IP, streams bitstream words, reports done/error.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pr_stream_ctrl
    import pr_stream_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [15:0]      src_data_i,
    input  logic             src_valid_i,
    input  logic             src_last_i,
    output logic             src_ready_o,
    output logic             pr_start_o,
    output logic [15:0]      pr_data_o,
    output logic             pr_data_valid_o,
    input  logic             pr_data_ready_i,
    input  logic [2:0]       pr_status_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [2:0]       err_code_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic               pr_start_q, pr_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [PAYLOAD_W-1:0] buf_data;
    logic                 buf_valid, buf_ready, buf_en, buf_flush;
    logic                 xfer, last_xfer, tick, timeout;

    pr_skid_buf #(.W(PAYLOAD_W)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (buf_flush),
        .en_i        (buf_en),
        .in_data_i   ({src_last_i, src_data_i}),
        .in_valid_i  (src_valid_i),
        .in_ready_o  (src_ready_o),
        .out_data_o  (buf_data),
        .out_valid_o (buf_valid),
        .out_ready_i (buf_ready)
    );

    assign pr_data_o       = buf_data[DATA_W-1:0];
    assign pr_data_valid_o = buf_valid && (state_q == ST_STREAM);
    assign buf_ready       = pr_data_ready_i && (state_q == ST_STREAM);
    assign buf_en          = (state_d == ST_STREAM);
    assign buf_flush       = (state_d == ST_DONE) || (state_d == ST_ERROR);

    assign pr_start_o = pr_start_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_code_q;
    assign word_cnt_o = word_cnt_q;

    always_comb begin
        state_d    = state_q;
        pr_start_d = 1'b0;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        word_cnt_d = word_cnt_q;

        xfer      = pr_data_valid_o && pr_data_ready_i;
        last_xfer = xfer && buf_data[DATA_W];
        tick      = (state_q == ST_START) || (state_q == ST_WAIT_DONE) ||
                    ((state_q == ST_STREAM) && !xfer);
        timeout   = tick && (timer_q == TMO_LAST);

        if (xfer && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_START, ST_STREAM, ST_WAIT_DONE: begin
                // Fault checks outrank the last-word hand-off in the same cycle.
                if (is_ip_fault(pr_status_i)) begin
                    state_d    = ST_ERROR;
                    err_code_d = pr_status_i;
                end else if ((pr_status_i == PR_ST_SUCCESS) && (state_q != ST_WAIT_DONE)) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_PREMATURE;
                end else if (timeout) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else if ((state_q == ST_START) && (pr_status_i == PR_ST_IN_PROGRESS)) begin
                    state_d = ST_STREAM;
                end else if ((state_q == ST_STREAM) && last_xfer) begin
                    state_d = ST_WAIT_DONE;
                end else if ((state_q == ST_WAIT_DONE) && (pr_status_i == PR_ST_SUCCESS)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
                if (state_d == ST_ERROR) begin
                    error_d = 1'b1;
                end
            end
            default: begin
                if (start_i) begin
                    state_d    = ST_START;
                    pr_start_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    word_cnt_d = '0;
                end
            end
        endcase

        if ((state_d != state_q) || xfer) begin
            timer_d = '0;
        end else if (tick) begin
            timer_d = timer_q + TMR_W'(1);
        end else begin
            timer_d = timer_q;
        end

        busy_d = (state_d == ST_START) || (state_d == ST_STREAM) ||
                 (state_d == ST_WAIT_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pr_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            word_cnt_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            pr_start_q <= pr_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            word_cnt_q <= word_cnt_d;
            timer_q    <= timer_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pr_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pr_stream_ctrl: randomized stimulus against a queue-based reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pr_stream_ctrl;

    localparam int TMO = 16;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [15:0]   src_data_i;
    logic          src_valid_i;
    logic          src_last_i;
    logic          src_ready_o;
    logic          pr_start_o;
    logic [15:0]   pr_data_o;
    logic          pr_data_valid_o;
    logic          pr_data_ready_i;
    logic [2:0]    pr_status_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [2:0]    err_code_o;
    logic [CW-1:0] word_cnt_o;

    pr_stream_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .src_data_i      (src_data_i),
        .src_valid_i     (src_valid_i),
        .src_last_i      (src_last_i),
        .src_ready_o     (src_ready_o),
        .pr_start_o      (pr_start_o),
        .pr_data_o       (pr_data_o),
        .pr_data_valid_o (pr_data_valid_o),
        .pr_data_ready_i (pr_data_ready_i),
        .pr_status_i     (pr_status_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .err_code_o      (err_code_o),
        .word_cnt_o      (word_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 start, 2 stream, 3 wait, 4 done, 5 error.
    int             m_ph, m_timer, m_code;
    logic [31:0]    m_cnt;
    bit             m_done, m_err, m_pstart, m_rdy;
    logic [16:0]    m_q[$];

    always @(negedge clk) begin
        bit busy_e, pv_e, acc, xfer, lastw, tick;
        int nph;
        if (rst) begin
            m_ph = 0; m_timer = 0; m_code = 0; m_cnt = 0;
            m_done = 0; m_err = 0; m_pstart = 0; m_rdy = 0;
            m_q.delete();
        end else begin
            busy_e = (m_ph >= 1) && (m_ph <= 3);
            pv_e   = (m_ph == 2) && (m_q.size() > 0);
            chk("busy", busy_o, busy_e);
            chk("done", done_o, m_done);
            chk("error", error_o, m_err);
            chk("err_code", err_code_o, m_code);
            chk("word_cnt", word_cnt_o, m_cnt);
            chk("pr_start", pr_start_o, m_pstart);
            chk("src_ready", src_ready_o, m_rdy);
            chk("pr_data_valid", pr_data_valid_o, pv_e);
            if (pv_e) chk("pr_data", pr_data_o, m_q[0][15:0]);

            acc   = src_valid_i && m_rdy;
            xfer  = pv_e && pr_data_ready_i;
            lastw = xfer && m_q[0][16];
            nph   = m_ph;
            if (m_ph == 0 || m_ph >= 4) begin
                m_pstart = 0;
                if (start_i) begin
                    nph = 1; m_done = 0; m_err = 0; m_code = 0;
                    m_cnt = 0; m_timer = 0; m_pstart = 1;
                end
            end else begin
                m_pstart = 0;
                tick = (m_ph != 2) || !xfer;
                if (xfer) begin
                    void'(m_q.pop_front());
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                end
                if (pr_status_i >= 3'd1 && pr_status_i <= 3'd3) begin
                    nph = 5; m_code = int'(pr_status_i);
                end else if (pr_status_i == 3'd5 && m_ph != 3) begin
                    nph = 5; m_code = 7;
                end else if (tick && m_timer == TMO - 1) begin
                    nph = 5; m_code = 6;
                end else if (m_ph == 1 && pr_status_i == 3'd4) begin
                    nph = 2;
                end else if (lastw) begin
                    nph = 3;
                end else if (m_ph == 3 && pr_status_i == 3'd5) begin
                    nph = 4; m_done = 1;
                end
                if (nph == 5) m_err = 1;
                if (nph != m_ph || xfer) m_timer = 0;
                else if (tick) m_timer++;
                if (acc) m_q.push_back({src_last_i, src_data_i});
                if (nph >= 4) m_q.delete();
            end
            m_ph  = nph;
            m_rdy = (nph == 2) && (m_q.size() < 2);
        end
    end

    task automatic idle_inputs();
        start_i = 0; src_valid_i = 0; src_last_i = 0; src_data_i = '0;
        pr_data_ready_i = 0; pr_status_i = 3'b000;
    endtask

    // mode: 0 nominal, 1 CRC after 5 words, 2 never in-progress,
    //       3 success after 3 words + start while busy, 4 reset at word 4
    task automatic run_op(input int n, input int rdy_pct, input int val_pct, input int mode,
                          output int s_cyc, output int e_cyc, output int pulses);
        logic [15:0] words[$];
        logic [15:0] got[$];
        int idx, ipw, cyc, since, after_last;
        bit fin;
        idx = 0; ipw = 0; cyc = 0; since = -1; after_last = -1; fin = 0;
        s_cyc = -1; e_cyc = -1; pulses = 0;
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
        start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        while (1) begin
            if (pr_start_o) begin pulses++; since = 0; s_cyc = cyc; end
            else if (since >= 0) since++;
            if (after_last >= 0) after_last++;
            if (mode == 4 && ipw == 4) begin
                rst = 1; #1;
                chk("rst_busy", busy_o, 0);
                chk("rst_pr_start", pr_start_o, 0);
                chk("rst_src_ready", src_ready_o, 0);
                chk("rst_pr_valid", pr_data_valid_o, 0);
                chk("rst_pr_data", pr_data_o, 0);
                chk("rst_word_cnt", word_cnt_o, 0);
                chk("rst_err_code", err_code_o, 0);
                idle_inputs();
                @(posedge clk); #1;
                rst = 0;
                break;
            end
            if (error_o || done_o) begin e_cyc = cyc; fin = 1; break; end
            if (cyc >= 400) break;
            pr_status_i = (mode != 2 && since >= 2) ? 3'b100 : 3'b000;
            if ((mode == 0 || mode == 4) && after_last >= 3) pr_status_i = 3'b101;
            if (mode == 1 && ipw >= 5) pr_status_i = 3'b010;
            if (mode == 3 && ipw >= 3) pr_status_i = 3'b101;
            start_i     = (mode == 3) && (ipw == 1);
            src_valid_i = (idx < n) && ($urandom_range(99) < val_pct);
            src_data_i  = (idx < n) ? words[idx] : 16'h0;
            src_last_i  = (idx == n - 1);
            pr_data_ready_i = ($urandom_range(99) < rdy_pct);
            if (src_valid_i && src_ready_o) idx++;
            if (pr_data_valid_o && pr_data_ready_i) begin
                got.push_back(pr_data_o);
                ipw++;
                if (ipw == n) after_last = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("op_finished", fin, mode != 4);
        if (mode == 0) begin
            chk("recv_count", got.size(), n);
            for (int i = 0; i < n && i < got.size(); i++) chk("recv_order", got[i], words[i]);
        end
        idle_inputs();
    endtask

    initial begin
        int s, e, p;
        rst = 1;
        idle_inputs();
        #2;
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_error", error_o, 0);
        chk("reset_src_ready", src_ready_o, 0);
        chk("reset_pr_valid", pr_data_valid_o, 0);
        chk("reset_word_cnt", word_cnt_o, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        run_op(8, 100, 100, 0, s, e, p);
        chk("nom_done", done_o, 1);
        chk("nom_error", error_o, 0);
        chk("nom_word_cnt", word_cnt_o, 8);
        chk("nom_pulses", p, 1);
        chk("nom_start_latency", s, 0);
        repeat (2) @(posedge clk); #1;

        run_op(20, 50, 90, 0, s, e, p);
        chk("bp_done", done_o, 1);
        chk("bp_word_cnt", word_cnt_o, 20);
        repeat (2) @(posedge clk); #1;

        run_op(10, 100, 100, 1, s, e, p);
        chk("crc_error", error_o, 1);
        chk("crc_code", err_code_o, 3'b010);
        chk("crc_src_ready", src_ready_o, 0);
        chk("crc_pr_valid", pr_data_valid_o, 0);
        repeat (2) @(posedge clk); #1;

        run_op(8, 100, 100, 2, s, e, p);
        chk("tmo_error", error_o, 1);
        chk("tmo_code", err_code_o, 3'b110);
        chk("tmo_cycles", e - s, 16);
        repeat (2) @(posedge clk); #1;

        run_op(8, 100, 100, 3, s, e, p);
        chk("prem_error", error_o, 1);
        chk("prem_code", err_code_o, 3'b111);
        chk("prem_pulses", p, 1);
        repeat (2) @(posedge clk); #1;

        run_op(8, 100, 100, 4, s, e, p);
        chk("post_rst_busy", busy_o, 0);
        repeat (2) @(posedge clk); #1;

        run_op(8, 100, 100, 0, s, e, p);
        chk("rerun_done", done_o, 1);
        chk("rerun_word_cnt", word_cnt_o, 8);
        repeat (2) @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
